// File: rtl/time_date_display_scan.sv
// Reader side of the time/date counter: snapshots one page per frame, converts each
// field to two BCD digits with a serial double-dabble, and scans a 6-digit common-anode display.
module time_date_display_scan #(
    parameter int DIGIT_CYCLES = 32,
    parameter int BLINK_HALF   = 16384
) (
    input  logic       clk_32_768K,
    input  logic       Rst_n,
    input  logic [5:0] Sec_Time,
    input  logic [5:0] Min_Time,
    input  logic [4:0] Hr_Time,
    input  logic [5:0] Day_Date,
    input  logic [3:0] Mon_Date,
    input  logic [6:0] Year_Date,
    input  logic [1:0] Blink,
    input  logic       Display,
    output logic [6:0] Seg_n,
    output logic       Dp_n,
    output logic [5:0] Dig_n,
    output logic       Frame
);
    localparam int TW = $clog2(DIGIT_CYCLES);
    localparam int BW = $clog2(BLINK_HALF);
    localparam logic [3:0] CODE_DASH  = 4'hA;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CONV, S_DONE} conv_state_e;
    conv_state_e state, state_d;

    logic [TW-1:0] slot_tmr;
    logic [2:0]    scan_idx;
    logic [6:0]    page_fld [3];
    logic [6:0]    snap1, snap2;
    logic [6:0]    sh_bin;
    logic [7:0]    sh_bcd;
    logic [3:0]    ones_adj, tens_adj;
    logic [8:0]    bcd_step;
    logic [2:0]    bit_cnt;
    logic [1:0]    fld;
    logic [3:0]    conv_res [6];
    logic [3:0]    digit_buf [6];
    logic [3:0]    cur_code;
    logic [1:0]    blink_q;
    logic [BW-1:0] blink_tmr, blink_tmr_d;
    logic          blink_phase, blink_phase_d, blink_hide;

    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        case (code)
            4'd0:      seg_decode = 7'b1000000;
            4'd1:      seg_decode = 7'b1111001;
            4'd2:      seg_decode = 7'b0100100;
            4'd3:      seg_decode = 7'b0110000;
            4'd4:      seg_decode = 7'b0011001;
            4'd5:      seg_decode = 7'b0010010;
            4'd6:      seg_decode = 7'b0000010;
            4'd7:      seg_decode = 7'b1111000;
            4'd8:      seg_decode = 7'b0000000;
            4'd9:      seg_decode = 7'b0010000;
            CODE_DASH: seg_decode = 7'b0111111;
            default:   seg_decode = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clk_32_768K or negedge Rst_n) begin
        if (!Rst_n) begin
            slot_tmr <= '0;
            scan_idx <= '0;
        end else if (slot_tmr == TW'(DIGIT_CYCLES - 1)) begin
            slot_tmr <= '0;
            scan_idx <= (scan_idx == 3'd5) ? 3'd0 : scan_idx + 3'd1;
        end else begin
            slot_tmr <= slot_tmr + TW'(1);
        end
    end

    always_comb begin
        if (Display) begin
            page_fld[0] = {1'b0, Day_Date};
            page_fld[1] = {3'b000, Mon_Date};
            page_fld[2] = Year_Date;
        end else begin
            page_fld[0] = {1'b0, Sec_Time};
            page_fld[1] = {1'b0, Min_Time};
            page_fld[2] = {2'b00, Hr_Time};
        end
    end

    // One double-dabble step; bcd_step[8] is the hundreds bit, set only for values above 99.
    always_comb begin
        ones_adj = (sh_bcd[3:0] >= 4'd5) ? sh_bcd[3:0] + 4'd3 : sh_bcd[3:0];
        tens_adj = (sh_bcd[7:4] >= 4'd5) ? sh_bcd[7:4] + 4'd3 : sh_bcd[7:4];
        bcd_step = {tens_adj, ones_adj, sh_bin[6]};
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (Frame) state_d = S_LOAD;
            S_LOAD:  state_d = S_CONV;
            S_CONV:  if (bit_cnt == 3'd6 && fld == 2'd2) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_32_768K or negedge Rst_n) begin
        if (!Rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk_32_768K or negedge Rst_n) begin
        if (!Rst_n) begin
            snap1   <= '0;
            snap2   <= '0;
            sh_bin  <= '0;
            sh_bcd  <= '0;
            bit_cnt <= '0;
            fld     <= '0;
            for (int i = 0; i < 6; i++) conv_res[i] <= CODE_BLANK;
        end else if (state == S_LOAD) begin
            snap1   <= page_fld[1];
            snap2   <= page_fld[2];
            sh_bin  <= page_fld[0];
            sh_bcd  <= '0;
            bit_cnt <= '0;
            fld     <= '0;
        end else if (state == S_CONV) begin
            if (bit_cnt == 3'd6) begin
                conv_res[{fld, 1'b0}] <= bcd_step[8] ? CODE_DASH : bcd_step[3:0];
                conv_res[{fld, 1'b1}] <= bcd_step[8] ? CODE_DASH : bcd_step[7:4];
                fld     <= fld + 2'd1;
                sh_bin  <= (fld == 2'd0) ? snap1 : snap2;
                sh_bcd  <= '0;
                bit_cnt <= '0;
            end else begin
                sh_bin  <= {sh_bin[5:0], 1'b0};
                sh_bcd  <= bcd_step[7:0];
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk_32_768K or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < 6; i++) digit_buf[i] <= CODE_BLANK;
        end else if (state == S_DONE) begin
            for (int i = 0; i < 6; i++) digit_buf[i] <= conv_res[i];
        end
    end

    // A change of Blink restarts the flash with the newly selected pair visible.
    always_comb begin
        if (Blink != blink_q) begin
            blink_tmr_d   = '0;
            blink_phase_d = 1'b0;
        end else if (blink_tmr == BW'(BLINK_HALF - 1)) begin
            blink_tmr_d   = '0;
            blink_phase_d = ~blink_phase;
        end else begin
            blink_tmr_d   = blink_tmr + BW'(1);
            blink_phase_d = blink_phase;
        end
        blink_hide = blink_phase_d && (Blink != 2'b00) && (Blink == scan_idx[2:1] + 2'd1);
    end

    always_ff @(posedge clk_32_768K or negedge Rst_n) begin
        if (!Rst_n) begin
            blink_q     <= 2'b00;
            blink_tmr   <= '0;
            blink_phase <= 1'b0;
        end else begin
            blink_q     <= Blink;
            blink_tmr   <= blink_tmr_d;
            blink_phase <= blink_phase_d;
        end
    end

    // DONE forwards the fresh conversion so the new frame is visible the cycle the buffer loads.
    assign cur_code = (state == S_DONE) ? conv_res[scan_idx] : digit_buf[scan_idx];

    always_ff @(posedge clk_32_768K or negedge Rst_n) begin
        if (!Rst_n) begin
            Seg_n <= 7'h7F;
            Dp_n  <= 1'b1;
            Dig_n <= 6'h3F;
            Frame <= 1'b0;
        end else begin
            Frame <= (slot_tmr == '0) && (scan_idx == 3'd0);
            if (slot_tmr == '0) begin
                Seg_n <= 7'h7F;
                Dp_n  <= 1'b1;
                Dig_n <= 6'h3F;
            end else begin
                Seg_n <= blink_hide ? 7'h7F : seg_decode(cur_code);
                Dp_n  <= ~((scan_idx == 3'd2) || (scan_idx == 3'd4));
                Dig_n <= ~(6'b000001 << scan_idx);
            end
        end
    end
endmodule

// File: tb/tb_time_date_display_scan.sv
// Bench for time_date_display_scan: frame-position model checked every cycle plus literal digit checks.
module tb_time_date_display_scan;
    localparam int DC = 8;
    localparam int BH = 512;
    localparam int FR = 6 * DC;

    logic       clk_32_768K = 1'b0;
    logic       Rst_n;
    logic [5:0] Sec_Time, Min_Time, Day_Date;
    logic [4:0] Hr_Time;
    logic [3:0] Mon_Date;
    logic [6:0] Year_Date;
    logic [1:0] Blink;
    logic       Display;
    logic [6:0] Seg_n;
    logic       Dp_n;
    logic [5:0] Dig_n;
    logic       Frame;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk_32_768K = ~clk_32_768K;

    time_date_display_scan #(.DIGIT_CYCLES(DC), .BLINK_HALF(BH)) dut (
        .clk_32_768K(clk_32_768K), .Rst_n(Rst_n),
        .Sec_Time(Sec_Time), .Min_Time(Min_Time), .Hr_Time(Hr_Time),
        .Day_Date(Day_Date), .Mon_Date(Mon_Date), .Year_Date(Year_Date),
        .Blink(Blink), .Display(Display),
        .Seg_n(Seg_n), .Dp_n(Dp_n), .Dig_n(Dig_n), .Frame(Frame)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] digit_seg(input int d);
        case (d)
            0: return 7'b1000000;  1: return 7'b1111001;
            2: return 7'b0100100;  3: return 7'b0110000;
            4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;
            8: return 7'b0000000;  9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] pair_code(input int v, input bit tens);
        if (v > 99) return 7'b0111111;
        return digit_seg(tens ? v / 10 : v % 10);
    endfunction

    // Model: position in frame since reset, snapshot at the LOAD edge, shown from frame cycle 24.
    int         k, m, pos, slot, tmr;
    int         vals [3];
    logic [1:0] last_b;
    logic [6:0] shown [6];
    logic [6:0] pend [6];
    logic [6:0] exp_seg;
    logic [5:0] exp_dig;
    logic       exp_dp, exp_frame, hidden;

    initial begin
        forever begin
            @(posedge clk_32_768K or negedge Rst_n);
            if (!Rst_n) begin
                k = 0; m = 0; last_b = 2'b00;
                for (int i = 0; i < 6; i++) begin shown[i] = 7'h7F; pend[i] = 7'h7F; end
                exp_seg = 7'h7F; exp_dig = 6'h3F; exp_dp = 1'b1; exp_frame = 1'b0;
            end else begin
                k++;
                if (Blink !== last_b) m = 0; else m++;
                last_b = Blink;
                pos = (k - 1) % FR;
                if (pos == 2) begin
                    vals[0] = Display ? int'(Day_Date)  : int'(Sec_Time);
                    vals[1] = Display ? int'(Mon_Date)  : int'(Min_Time);
                    vals[2] = Display ? int'(Year_Date) : int'(Hr_Time);
                    for (int p = 0; p < 3; p++) begin
                        pend[2*p]   = pair_code(vals[p], 1'b0);
                        pend[2*p+1] = pair_code(vals[p], 1'b1);
                    end
                end
                if (pos == 24) for (int i = 0; i < 6; i++) shown[i] = pend[i];
                slot = pos / DC;
                tmr  = pos % DC;
                exp_frame = (pos == 0);
                if (tmr == 0) begin
                    exp_seg = 7'h7F; exp_dig = 6'h3F; exp_dp = 1'b1;
                end else begin
                    hidden  = (Blink != 2'b00) && (int'(Blink) - 1 == slot / 2) && (((m / BH) % 2) == 1);
                    exp_dig = ~(6'b000001 << slot);
                    exp_dp  = !(slot == 2 || slot == 4);
                    exp_seg = hidden ? 7'h7F : shown[slot];
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_32_768K);
            if (!Rst_n) begin
                check("rst_seg", Seg_n, 7'h7F);
                check("rst_dig", Dig_n, 6'h3F);
                check("rst_dp", Dp_n, 1'b1);
                check("rst_frame", Frame, 1'b0);
            end else begin
                check("seg", Seg_n, exp_seg);
                check("dig", Dig_n, exp_dig);
                check("dp", Dp_n, exp_dp);
                check("frame", Frame, exp_frame);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_32_768K);
    endtask

    task automatic wait_frame();
        int c = 0;
        do begin @(negedge clk_32_768K); c++; end while (Frame !== 1'b1 && c < 200);
        if (Frame !== 1'b1) begin
            tests_run++; tests_failed++;
            $display("FAIL frame_timeout: no Frame within 200 cycles at %0t", $time);
        end
    endtask

    task automatic wait_digit(input int idx);
        int c = 0;
        logic [5:0] want;
        want = ~(6'b000001 << idx);
        while (Dig_n !== want && c < 100) begin @(negedge clk_32_768K); c++; end
        if (Dig_n !== want) begin
            tests_run++; tests_failed++;
            $display("FAIL digit_timeout: digit %0d never enabled, Dig_n=%0h at %0t", idx, Dig_n, $time);
        end
    endtask

    initial begin
        int c;
        Rst_n = 1'b0;
        Sec_Time = 6'd7; Min_Time = 6'd59; Hr_Time = 5'd23;
        Day_Date = 6'd31; Mon_Date = 4'd12; Year_Date = 7'd99;
        Blink = 2'b00; Display = 1'b0;
        tick(3);
        #1 Rst_n = 1'b1;
        @(negedge clk_32_768K);
        check("frame_first", Frame, 1'b1);

        // Time page 23:59:07
        tick(FR);
        wait_digit(0); check("t_d0", Seg_n, 7'b1111000); check("t_d0_dp", Dp_n, 1'b1);
        wait_digit(2); check("t_d2", Seg_n, 7'b0010000); check("t_d2_dp", Dp_n, 1'b0);
        wait_digit(4); check("t_d4", Seg_n, 7'b0110000); check("t_d4_dp", Dp_n, 1'b0);
        wait_digit(5); check("t_d5", Seg_n, 7'b0100100);

        wait_frame();
        c = 0;
        do begin @(negedge clk_32_768K); c++; end while (Frame !== 1'b1 && c < 200);
        check("frame_period", c, FR);

        // Reset in the middle of conversion
        wait_frame(); tick(10);
        #2 Rst_n = 1'b0;
        #1;
        check("arst_seg", Seg_n, 7'h7F); check("arst_dig", Dig_n, 6'h3F);
        check("arst_dp", Dp_n, 1'b1);    check("arst_frame", Frame, 1'b0);
        tick(2);
        #1 Rst_n = 1'b1;
        @(negedge clk_32_768K);
        check("arst_frame_first", Frame, 1'b1);
        tick(23);
        check("arst_f23_dig", Dig_n, 6'b111011); check("arst_f23_blank", Seg_n, 7'h7F);
        tick(2);
        check("arst_f25_dig", Dig_n, 6'b110111); check("arst_f25_seg", Seg_n, 7'b0010010);

        // Date page 99-12-31, then Day changes mid-frame
        #1 Display = 1'b1;
        tick(2 * FR);
        wait_digit(5); check("d_d5", Seg_n, 7'b0010000);
        wait_digit(1); check("d_d1", Seg_n, 7'b0110000);
        wait_digit(0); check("d_d0", Seg_n, 7'b1111001);
        wait_frame(); tick(5);
        #1 Day_Date = 6'd1;
        wait_digit(1); check("day_hold", Seg_n, 7'b0110000);
        wait_frame(); tick(25);
        wait_digit(1); check("day_new_d1", Seg_n, 7'b1000000);
        wait_digit(0); check("day_new_d0", Seg_n, 7'b1111001);

        // Out of range year
        #1 Year_Date = 7'd100;
        tick(2 * FR);
        wait_digit(5); check("oor_d5", Seg_n, 7'b0111111);
        wait_digit(4); check("oor_d4", Seg_n, 7'b0111111);
        wait_digit(3); check("oor_d3", Seg_n, 7'b1111001);
        #1 Year_Date = 7'd127;
        tick(2 * FR);
        wait_digit(4); check("oor127_d4", Seg_n, 7'b0111111);

        // Blink pair1 on the time page, then pair2
        #1 Display = 1'b0; Blink = 2'b10;
        tick(2 * FR);
        wait_digit(2); check("blink_vis_d2", Seg_n, 7'b0010000);
        tick(BH);
        wait_digit(2); check("blink_hid_d2", Seg_n, 7'h7F);
        wait_digit(4); check("blink_steady_d4", Seg_n, 7'b0110000);
        tick(BH);
        wait_digit(3); check("blink_vis2_d3", Seg_n, 7'b0010010);
        #1 Blink = 2'b11;
        wait_digit(4); check("blink11_vis_d4", Seg_n, 7'b0110000);
        tick(BH);
        wait_digit(4); check("blink11_hid_d4", Seg_n, 7'h7F);
        wait_digit(2); check("blink11_steady_d2", Seg_n, 7'b0010000);
        #1 Blink = 2'b00;
        tick(2 * FR);
        wait_digit(4); check("blink_off_d4", Seg_n, 7'b0110000);
        tick(FR);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "watchdog");
    end
endmodule
